button_event_scheduler: RTL

//   Serialises the debounced key strobes (A, S, W, X press, X release, D) into one ordered event

---
 rtl/button_event_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/button_event_scheduler.sv
// button_event_scheduler
//   Turns debounced key levels (A, S, W, X press, X release, D) into one ordered
//   stream of event codes. Rising edges latch a per-key pending bit, a round-robin
//   arbiter moves one pending key per cycle into a small FIFO, and the consumer
//   drains the FIFO with valid/ready. A rise on a key that is still pending is a
//   lost event and sets the sticky ovf_flag.
//   Optional feature macro: EVT_DROP_CNT_EN adds an 8-bit saturating drop counter.
module button_event_scheduler #(
  parameter int N_REQ      = 6,
  parameter int CODE_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              buttom_rst,
  input  logic [N_REQ-1:0]  req_level,
  input  logic              evt_ready,
  input  logic              clr_ovf,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              ovf_flag
`ifdef EVT_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [N_REQ-1:0]  req_prev;
  logic [N_REQ-1:0]  pend;
  logic [CODE_W-1:0] last_grant;
  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic [N_REQ-1:0]  rise;
  logic [N_REQ-1:0]  gnt_oh;
  logic [N_REQ-1:0]  drop_vec;
  logic [CODE_W-1:0] gnt_idx;
  logic              gnt_valid;
  logic              pop;
  logic              push_ok;

  assign rise      = req_level & ~req_prev;
  assign evt_valid = (fifo_count != '0);
  assign pop       = evt_valid & evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = (fifo_count < CNT_W'(FIFO_DEPTH)) | pop;
  // A rise on a key whose previous event is still waiting is lost, unless that
  // key is granted this very cycle (then the new rise simply re-arms it).
  assign drop_vec  = rise & pend & ~gnt_oh;
  assign evt_code  = evt_valid ? mem[rd_ptr] : '0;

  // Round-robin arbiter: first pending key after last_grant, wrapping at N_REQ.
  always_comb begin
    logic [CODE_W:0]   sum;
    logic [CODE_W-1:0] idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    sum       = '0;
    idx       = '0;
    if (push_ok) begin
      for (int off = 1; off <= N_REQ; off++) begin
        sum = {1'b0, last_grant} + (CODE_W+1)'(off);
        if (sum >= (CODE_W+1)'(N_REQ)) sum = sum - (CODE_W+1)'(N_REQ);
        idx = sum[CODE_W-1:0];
        if (!gnt_valid && pend[idx]) begin
          gnt_valid   = 1'b1;
          gnt_idx     = idx;
          gnt_oh[idx] = 1'b1;
        end
      end
    end
  end

  // Edge history, pending bits and arbiter history.
  always_ff @(posedge clk or posedge buttom_rst) begin
    if (buttom_rst) begin
      req_prev   <= '1;
      pend       <= '0;
      last_grant <= CODE_W'(N_REQ-1);
    end else begin
      req_prev <= req_level;
      pend     <= (pend & ~gnt_oh) | rise;
      if (gnt_valid) last_grant <= gnt_idx;
    end
  end

  // Event FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge buttom_rst) begin
    if (buttom_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (gnt_valid) begin
        mem[wr_ptr] <= gnt_idx;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (gnt_valid && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !gnt_valid) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  // Sticky loss flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge buttom_rst) begin
    if (buttom_rst)       ovf_flag <= 1'b0;
    else if (|drop_vec)   ovf_flag <= 1'b1;
    else if (clr_ovf)     ovf_flag <= 1'b0;
  end

`ifdef EVT_DROP_CNT_EN
  logic [7:0] n_drop;
  logic [8:0] drop_sum;

  // Number of keys losing an event this cycle, added onto the (possibly cleared) count.
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_REQ; i++) n_drop = n_drop + 8'(drop_vec[i]);
    drop_sum = {1'b0, (clr_ovf ? 8'd0 : drop_cnt)} + {1'b0, n_drop};
  end

  // Saturating drop counter.
  always_ff @(posedge clk or posedge buttom_rst) begin
    if (buttom_rst) drop_cnt <= '0;
    else            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
`endif

endmodule
